syscall_sequencer: RTL and testbench
====================================

SYSCALL_SEQUENCER -- requirements
Module: syscall_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEBOUNCE_CYCLES, 16, cycles the synchronised finish level must be stable before the debounced level changes.
- PRINT_HOLD_CYCLES, 8, cycles the datapath stays stalled during a print service.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock, rising edge; the block's only clock.
- rst, in, 1, synchronous active-high reset.
- ecall_valid, in, 1, current instruction is ecall (opcode 1110011, funct3 000).
- a7, in, 32, service number from register x17.
- a0, in, 32, argument from register x10.
- switch_in, in, 8, board switches.
- keyboard_in, in, 32, keypad value.
- finish, in, 1, raw asynchronous confirm button, active high.
- stall, out, 1, holds PC and blocks register/memory writes when high.
- wb_en, out, 1, one-cycle request to write wb_data into x10.
- wb_data, out, 32, value written to x10.
- tube_data, out, 32, value shown on the seven-segment tube.
- halted, out, 1, program has exited.
REQ-003 The block SHALL use one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-004 The FSM SHALL have the states IDLE, PRINT, WAIT_IN, WRITE, DONE and HALT.
REQ-005 stall SHALL be combinational: high when (state==IDLE && ecall_valid) or state is in {PRINT, WAIT_IN, WRITE, HALT}; low in DONE.
REQ-006 From IDLE with ecall_valid, the next state SHALL be decoded from a7:
- a7==1: go to PRINT.
- a7==5 or a7==12: go to WAIT_IN, latching the service.
- a7==10: go to HALT.
- any other value: go to DONE.
REQ-007 On the IDLE->PRINT transition, tube_data SHALL load a0; tube_data SHALL otherwise keep its value.
REQ-008 PRINT SHALL last exactly PRINT_HOLD_CYCLES cycles, then move to DONE; its counter SHALL clear on entry.
REQ-009 finish SHALL pass through a 2-flop synchroniser and then a debouncer. The debounced level SHALL change only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles. press is a one-cycle pulse on a debounced rising edge.
REQ-010 WAIT_IN SHALL move to WRITE only on a press that occurs while in WAIT_IN. A button already held on entry SHALL NOT count; the button must be released and pressed again.
REQ-011 In WRITE, wb_en SHALL be 1 for exactly one cycle. wb_data SHALL be keyboard_in for service 5, or {24'b0, switch_in} for service 12, both sampled in that cycle. Next state is DONE.
REQ-012 wb_en SHALL be 0 in every state except WRITE. wb_data SHALL be 0 whenever wb_en is 0.
REQ-013 DONE SHALL last one cycle with stall low so the PC advances past the ecall. It then goes to IDLE. ecall_valid SHALL be ignored in DONE.
REQ-014 Entry latency: the first stalled cycle is the ecall cycle itself. Release latency is 1 cycle (DONE) after PRINT or WRITE completes.
REQ-015 HALT SHALL be terminal until rst, with stall=1 and halted=1; finish and ecall_valid are ignored.
REQ-016 Back-to-back ecalls SHALL each be serviced: the ecall seen in IDLE after DONE starts a new service.
REQ-017 Service decode SHALL use the full 32-bit a7; a7=0x0000_0101 is unknown and goes to DONE.

Reset
REQ-018 While rst is sampled high:
- state SHALL go to IDLE.
- All counters, synchroniser flops, debounced level and latched service SHALL clear to 0.
- wb_en, wb_data, tube_data and halted SHALL be 0.
REQ-019 Reset SHALL take priority in every state, including mid-PRINT, mid-WAIT_IN and HALT. stall then follows REQ-005 from IDLE in the next cycle.

Verification
REQ-020 Print: a7=1, a0=0x1234_ABCD, ecall_valid for 1 cycle -> tube_data=0x1234_ABCD next cycle; stall high for the ecall cycle plus 8 PRINT cycles; then one DONE cycle with stall=0; wb_en never asserts.
REQ-021 Read keyboard: a7=5, keyboard_in=0x0000_0042, finish pulsed high for 40 cycles -> wb_en=1 for exactly one cycle with wb_data=0x0000_0042, about 19 cycles after the finish rising edge; stall drops one cycle later.
REQ-022 Held button and glitch: finish already high when a7=12 is entered, and finish high for only 10 cycles -> no wb_en. After a release and a 30-cycle press with switch_in=0xA5 -> wb_data=0x0000_00A5.
REQ-023 Exit and unknown: a7=10 -> halted=1 and stall=1 indefinitely, ignoring finish presses. a7=7 -> stall high 1 cycle, DONE 1 cycle, no wb_en, tube_data unchanged.
REQ-024 Reset mid-operation: rst high for 1 cycle during WAIT_IN or HALT -> next cycle state=IDLE, stall=0 (with ecall_valid=0), halted=0, tube_data=0; a subsequent a7=1 ecall is serviced normally.

Source files
------------

// File: rtl/syscall_sequencer.sv
// ECALL service sequencer: stalls the core while print, read-input and exit
// services run, and debounces the asynchronous confirm button.
module syscall_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter int unsigned PRINT_HOLD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall_valid,
    input  logic [31:0] a7,
    input  logic [31:0] a0,
    input  logic [7:0]  switch_in,
    input  logic [31:0] keyboard_in,
    input  logic        finish,
    output logic        stall,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic [31:0] tube_data,
    output logic        halted
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PR_W = $clog2(PRINT_HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRINT,
        WAIT_IN,
        WRITE,
        DONE,
        HALT
    } state_t;

    state_t          state, next_state;
    logic            sync1, sync2;
    logic            db_level;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    logic [PR_W-1:0] print_cnt;
    logic            svc_kbd;
    logic            armed;

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        wb_en      = 1'b0;
        wb_data    = '0;
        halted     = 1'b0;
        case (state)
            IDLE: begin
                if (ecall_valid) begin
                    stall = 1'b1;
                    if (a7 == 32'd1)
                        next_state = PRINT;
                    else if (a7 == 32'd5 || a7 == 32'd12)
                        next_state = WAIT_IN;
                    else if (a7 == 32'd10)
                        next_state = HALT;
                    else
                        next_state = DONE;
                end
            end
            PRINT: begin
                stall = 1'b1;
                if (print_cnt == PR_W'(PRINT_HOLD_CYCLES - 1))
                    next_state = DONE;
            end
            WAIT_IN: begin
                stall = 1'b1;
                if (press && armed)
                    next_state = WRITE;
            end
            WRITE: begin
                stall      = 1'b1;
                wb_en      = 1'b1;
                wb_data    = svc_kbd ? keyboard_in : {24'b0, switch_in};
                next_state = DONE;
            end
            DONE:    next_state = IDLE;
            HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            db_level  <= 1'b0;
            db_cnt    <= '0;
            press     <= 1'b0;
            print_cnt <= '0;
            svc_kbd   <= 1'b0;
            armed     <= 1'b0;
            tube_data <= '0;
        end else begin
            state <= next_state;
            sync1 <= finish;
            sync2 <= sync1;

            press <= 1'b0;
            if (sync2 != db_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                    press    <= sync2;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end

            if (state == IDLE && next_state == PRINT) begin
                print_cnt <= '0;
                tube_data <= a0;
            end else if (state == PRINT) begin
                print_cnt <= print_cnt + 1'b1;
            end

            if (state == IDLE && next_state == WAIT_IN)
                svc_kbd <= (a7 == 32'd5);

            // A press only counts once the button has been seen released in WAIT_IN.
            if (state != WAIT_IN)
                armed <= 1'b0;
            else if (!db_level)
                armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_syscall_sequencer.sv
// Scoreboard bench for syscall_sequencer: writebacks are queued as expected
// values and checked by an independent monitor; stall/tube/halted checked inline.
module tb_syscall_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall_valid;
    logic [31:0] a7;
    logic [31:0] a0;
    logic [7:0]  switch_in;
    logic [31:0] keyboard_in;
    logic        finish;
    logic        stall;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [31:0] tube_data;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    syscall_sequencer #(
        .DEBOUNCE_CYCLES  (16),
        .PRINT_HOLD_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ecall_valid(ecall_valid),
        .a7         (a7),
        .a0         (a0),
        .switch_in  (switch_in),
        .keyboard_in(keyboard_in),
        .finish     (finish),
        .stall      (stall),
        .wb_en      (wb_en),
        .wb_data    (wb_data),
        .tube_data  (tube_data),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every writeback must match the head of the expected queue.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {31'b0, wb_en}, 32'd0);
            end else begin
                chk("wb_data", wb_data, exp_q.pop_front());
            end
        end else begin
            chk("wb_data_idle_zero", wb_data, 32'd0);
        end
    end

    task automatic issue(input logic [31:0] svc, input logic [31:0] arg);
        @(posedge clk); #1;
        a7 = svc; a0 = arg; ecall_valid = 1'b1;
        @(negedge clk);
        chk("ecall_cycle_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        ecall_valid = 1'b0;
    endtask

    task automatic print_seq(input logic [31:0] arg);
        issue(32'd1, arg);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("print_stall", {31'b0, stall}, 32'd1);
            if (i == 0) chk("print_tube", tube_data, arg);
        end
        @(negedge clk);
        chk("print_done_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        chk("print_idle_stall", {31'b0, stall}, 32'd0);
        chk("print_tube_hold", tube_data, arg);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit done;
        rst = 1'b1; ecall_valid = 1'b0; a7 = '0; a0 = '0;
        switch_in = '0; keyboard_in = '0; finish = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_wb_en", {31'b0, wb_en}, 32'd0);
        chk("reset_tube", tube_data, 32'd0);
        chk("reset_halted", {31'b0, halted}, 32'd0);

        // Print service
        print_seq(32'h1234_ABCD);

        // Unknown services leave the tube untouched
        issue(32'd7, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("unk7_done_stall", {31'b0, stall}, 32'd0);
        chk("unk7_tube", tube_data, 32'h1234_ABCD);
        issue(32'h0000_0101, 32'h0);
        @(negedge clk);
        chk("unk101_done_stall", {31'b0, stall}, 32'd0);
        chk("unk101_halted", {31'b0, halted}, 32'd0);

        // Back-to-back unknown ecalls: IDLE, DONE, IDLE, DONE
        @(posedge clk); #1;
        a7 = 32'd7; ecall_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_stall", {31'b0, stall}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1 ecall_valid = 1'b0;

        // Keyboard read
        keyboard_in = 32'h0000_0042;
        issue(32'd5, 32'h0);
        exp_q.push_back(32'h0000_0042);
        repeat (3) @(negedge clk);
        chk("kbd_wait_stall", {31'b0, stall}, 32'd1);
        finish = 1'b1;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (wb_en && lat == 0) begin
                lat = k;
                chk("kbd_write_stall", {31'b0, stall}, 32'd1);
            end else if (lat != 0 && k == lat + 1) begin
                chk("kbd_release_stall", {31'b0, stall}, 32'd0);
            end
            if (k == 40) finish = 1'b0;
        end
        chk("kbd_latency_in_range", {31'b0, (lat >= 17 && lat <= 21)}, 32'd1);
        repeat (30) @(negedge clk);

        // Held button and glitch, then a real press
        finish = 1'b1;
        repeat (30) @(negedge clk);
        switch_in = 8'h3C;
        issue(32'd12, 32'h0);
        repeat (20) @(negedge clk);
        chk("held_no_write", {31'b0, stall}, 32'd1);
        finish = 1'b0;
        repeat (30) @(negedge clk);
        finish = 1'b1;
        repeat (10) @(negedge clk);
        finish = 1'b0;
        repeat (30) @(negedge clk);
        chk("glitch_no_write", {31'b0, stall}, 32'd1);
        switch_in = 8'hA5;
        exp_q.push_back(32'h0000_00A5);
        finish = 1'b1;
        done = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 30) finish = 1'b0;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        finish = 1'b0;
        chk("sw_write_seen", {31'b0, done}, 32'd1);
        repeat (30) @(negedge clk);
        chk("sw_back_idle", {31'b0, stall}, 32'd0);

        // Reset during WAIT_IN, then a normal print
        issue(32'd5, 32'h0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_stall", {31'b0, stall}, 32'd0);
        chk("rst_wait_halted", {31'b0, halted}, 32'd0);
        chk("rst_wait_tube", tube_data, 32'd0);
        print_seq(32'hCAFE_F00D);

        // Exit: terminal, ignores finish and ecalls
        issue(32'd10, 32'h0);
        @(negedge clk);
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        a7 = 32'd1; ecall_valid = 1'b1; finish = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 30) finish = 1'b0;
            if (k % 10 == 0) begin
                chk("halt_sticky_halted", {31'b0, halted}, 32'd1);
                chk("halt_sticky_stall", {31'b0, stall}, 32'd1);
            end
        end
        chk("halt_tube", tube_data, 32'hCAFE_F00D);
        @(posedge clk); #1;
        ecall_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_halt_stall", {31'b0, stall}, 32'd0);
        chk("rst_halt_halted", {31'b0, halted}, 32'd0);
        chk("rst_halt_tube", tube_data, 32'd0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
